// File: rtl/auction_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : auction_pkg
//  Purpose  : Shared types for the auction engine. Holds the FSM state
//             encoding and the pricing-mode encodings.
//  Revision : 1.0  initial release
// ============================================================================
package auction_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    localparam logic MODE_FIRST  = 1'b0;
    localparam logic MODE_SECOND = 1'b1;

endpackage : auction_pkg
`default_nettype wire

// File: rtl/auction_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : auction_cmp
//  Purpose  : Combinational unsigned comparator for one incoming bid against
//             the running maximum and the running second-highest value.
//  Ports    : bid, max_val, second_val  (W-bit unsigned inputs)
//             gt_max, eq_max, gt_second (1-bit flags)
//  Revision : 1.0  initial release
// ============================================================================
module auction_cmp
    import auction_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] bid,
    input  logic [W-1:0] max_val,
    input  logic [W-1:0] second_val,
    output logic         gt_max,
    output logic         eq_max,
    output logic         gt_second
);

    // All operands are unsigned logic vectors, so these compare at full width.
    assign gt_max    = (bid >  max_val);
    assign eq_max    = (bid == max_val);
    assign gt_second = (bid >  second_val);

endmodule : auction_cmp
`default_nettype wire

// File: rtl/auction_engine.sv
`default_nettype none
// ============================================================================
//  Module   : auction_engine
//  Purpose  : Sealed-bid auction over N_BIDDERS sequential bids. Tracks the
//             highest and second-highest bid, the earliest winner and ties,
//             then presents a first- or second-price result with a
//             valid/ready handshake.
//  Ports    : clk, rst                 clock / synchronous active-high reset
//             start, mode              auction launch and pricing mode
//             bid_valid/ready/value    bid stream
//             res_valid/ready          result handshake
//             res_winner/price/tie/zero result fields
//             busy                     engine not idle
//  Revision : 1.0  initial release
// ============================================================================
module auction_engine
    import auction_pkg::*;
#(
    parameter int N_BIDDERS = 4,
    parameter int W         = 16,
    parameter int ID_W      = $clog2(N_BIDDERS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            bid_valid,
    output logic            bid_ready,
    input  logic [W-1:0]    bid_value,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ID_W-1:0] res_winner,
    output logic [W-1:0]    res_price,
    output logic            res_tie,
    output logic            res_zero,
    output logic            busy
);

    localparam logic [ID_W:0] c_LAST_IDX = (ID_W+1)'(N_BIDDERS - 1);

    state_t          state_q,  state_d;
    logic            mode_q,   mode_d;
    logic [W-1:0]    max_q,    max_d;
    logic [W-1:0]    second_q, second_d;
    logic [ID_W-1:0] winner_q, winner_d;
    logic            tie_q,    tie_d;
    logic [ID_W:0]   cnt_q,    cnt_d;

    logic w_gt_max;
    logic w_eq_max;
    logic w_gt_second;
    logic w_accept;
    logic w_in_result;

    auction_cmp #(
        .W (W)
    ) u_cmp (
        .bid        (bid_value),
        .max_val    (max_q),
        .second_val (second_q),
        .gt_max     (w_gt_max),
        .eq_max     (w_eq_max),
        .gt_second  (w_gt_second)
    );

    assign w_accept    = bid_valid && (state_q == S_COLLECT);
    assign w_in_result = (state_q == S_RESULT);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        max_d    = max_q;
        second_d = second_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_COLLECT;
                    mode_d   = mode;
                    max_d    = '0;
                    second_d = '0;
                    winner_d = '0;
                    tie_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        // First bid seeds the maximum whatever its value;
                        // second stays at its cleared value of 0.
                        max_d    = bid_value;
                        winner_d = '0;
                    end else if (w_gt_max) begin
                        second_d = max_q;
                        max_d    = bid_value;
                        winner_d = cnt_q[ID_W-1:0];
                        tie_d    = 1'b0;
                    end else if (w_eq_max) begin
                        // Winner is left alone so the earliest arrival keeps it.
                        second_d = bid_value;
                        tie_d    = 1'b1;
                    end else if (w_gt_second) begin
                        second_d = bid_value;
                    end
                    if (cnt_q == c_LAST_IDX) begin
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_FIRST;
            max_q    <= '0;
            second_q <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            max_q    <= max_d;
            second_q <= second_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs come only from registers and state. Result fields are masked
    // outside RESULT so that idle/reset values are all zero (max_q == 0 at
    // reset would otherwise show res_zero = 1).
    assign bid_ready  = (state_q == S_COLLECT);
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = w_in_result;
    assign res_winner = w_in_result ? winner_q : '0;
    assign res_price  = !w_in_result          ? '0       :
                        (mode_q == MODE_SECOND) ? second_q : max_q;
    assign res_tie    = w_in_result && tie_q;
    assign res_zero   = w_in_result && (max_q == '0);

endmodule : auction_engine
`default_nettype wire

// File: doc/auction_engine.md
AUCTION_ENGINE -- requirements
Module: auction_engine

Interface
REQ-001 The block SHALL expose parameter N_BIDDERS, default 4, meaning the number of bids per auction (legal range 2..64).
REQ-002 The block SHALL expose parameter W, default 16, meaning the bid width in bits (legal range 1..64).
REQ-003 The block SHALL expose parameter ID_W, default $clog2(N_BIDDERS), meaning the winner-index width.
REQ-004 Ports SHALL be as follows; one clock, reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new auction; honoured only in IDLE
- mode  in  1  0 = first-price, 1 = second-price; sampled with start
- bid_valid  in  1  bid offered
- bid_ready  out  1  engine accepts a bid this cycle
- bid_value  in  W  unsigned bid
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_winner  out  ID_W  arrival index (0-based) of the winning bid
- res_price  out  W  price charged
- res_tie  out  1  at least two bids equal the maximum
- res_zero  out  1  maximum bid is 0 (no real bid)
- busy  out  1  state is not IDLE

Function
REQ-005 The FSM SHALL have three states: IDLE, COLLECT and RESULT.
REQ-006 IDLE: start=1 -> COLLECT next cycle; mode latched; max, second, winner and tie registers cleared; bid counter = 0.
REQ-007 In COLLECT, bid_ready SHALL be 1; a bid is accepted on any cycle with bid_valid&bid_ready, at most one bid per cycle.
REQ-008 An accepted bid with index k (counter value) SHALL update state as follows:
- bid > max: second <= max, max <= bid, winner <= k, tie <= 0
- bid == max and k != 0: second <= bid, tie <= 1; winner unchanged, so the earliest arrival wins ties
- max > bid > second: second <= bid
- otherwise: no change
REQ-009 The bid at index 0 SHALL set max and winner unconditionally and leave second at 0.
REQ-010 After the N_BIDDERS-th accepted bid, the FSM SHALL enter RESULT on the next cycle; bid_ready SHALL be 0 outside COLLECT.
REQ-011 Result outputs in RESULT:
- res_valid = 1
- res_price = max if mode = 0, second if mode = 1
- res_zero = (max == 0)
- res_tie and res_winner from the registers
- all result outputs held stable until the handshake
REQ-012 Latency: res_valid SHALL rise exactly one cycle after the final bid is accepted.
REQ-013 RESULT with res_ready=1 SHALL return to IDLE next cycle; res_valid=1 and res_ready=0 SHALL hold RESULT indefinitely.
REQ-014 start asserted in COLLECT or RESULT SHALL be ignored.
REQ-015 All comparisons SHALL be unsigned at full width W; the counter SHALL be ID_W+1 bits wide and SHALL NOT wrap within one auction.
REQ-016 bid_valid gaps in COLLECT SHALL stall the engine with no timeout; gaps SHALL NOT change the result.
REQ-017 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs except none.

Reset
REQ-018 rst=1 at any clock edge, including mid-COLLECT or in RESULT, SHALL abort the auction and force IDLE on the next cycle.
REQ-019 Reset values SHALL be: bid_ready=0, res_valid=0, busy=0, res_winner=0, res_price=0, res_tie=0, res_zero=0, internal max/second/counter=0, latched mode=0.

Structure
REQ-020 A shared package auction_pkg SHALL hold the FSM state enum and the mode encodings (MODE_FIRST=0, MODE_SECOND=1).
REQ-021 A single sub-module auction_cmp (combinational, W-bit) SHALL compute the gt/eq flags of bid vs max and bid vs second; the FSM and registers SHALL remain in auction_engine.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (defaults N=4, W=16):
- First-price: bids 10, 40, 25, 5, mode 0 -> winner=1, price=40, tie=0, zero=0.
- Second-price: same bids, mode 1 -> winner=1, price=25.
- Tie: bids 7, 30, 30, 2, mode 1 -> winner=1, price=30, tie=1.
- All-zero bids, mode 0 -> winner=0, price=0, zero=1; and max-value case 0xFFFF, 0xFFFE, 0, 0, mode 1 -> winner=0, price=0xFFFE.
- Backpressure and stalls: bid_valid gaps of 3 cycles plus res_ready held 0 for 5 cycles -> outputs stable, single handshake, return to IDLE; start pulsed during COLLECT ignored.
- Reset after 2 of 4 bids -> IDLE next cycle, all outputs at reset values; a fresh auction then completes correctly.
